multi_pp_accum: RTL and testbench

// - Downstream stage of the 78x78 limb multiplier: takes its 15 partial products
//   (3 A-limbs of 26b x 5 B-limbs of 17b, each 43b) and sums them, with shifts,

---
 rtl/multi_pp_accum.sv | 162 ++++++++++++++++
 tb/tb_multi_pp_accum.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pp_accum.sv
`default_nettype none
// ============================================================================
// Module   : multi_pp_accum
// Purpose  : Accumulates the 15 partial products of a 78x78 limb multiplier
//            (3 A-limbs of 26b x 5 B-limbs of 17b, 43b each) into the
//            156-bit product. The default build adds one A-row (5 shifted
//            terms) per cycle. Defining MULTI_PP_FAST_EN adds all 15 terms
//            in a single cycle.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous reset, active-high
//            in_valid   - pp bus holds a valid set of partial products
//            in_ready   - block can accept a new set (IDLE only)
//            pp         - pp_k = pp[PP_W*k +: PP_W], k = i*N_B + j
//            out_valid  - prod is valid (DONE only)
//            out_ready  - consumer accepts prod
//            prod       - accumulated 2*RADIX-bit product
// Macro    : MULTI_PP_FAST_EN - single-cycle SUM state instead of 3 rows
// Revision : 1.0 - initial release
// ============================================================================
module multi_pp_accum #(
    parameter int RADIX  = 78,
    parameter int PP_W   = 43,
    parameter int A_LIMB = 26,
    parameter int B_LIMB = 17,
    parameter int N_A    = 3,
    parameter int N_B    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_A*N_B*PP_W-1:0] pp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*RADIX-1:0]      prod
);

    localparam int PROD_W   = 2 * RADIX;
    localparam int PP_BUS_W = N_A * N_B * PP_W;

    localparam logic [2:0] S_IDLE = 3'd0;
`ifdef MULTI_PP_FAST_EN
    localparam logic [2:0] S_SUM  = 3'd1;
`else
    localparam logic [2:0] S_ROW0 = 3'd1;
    localparam logic [2:0] S_ROW1 = 3'd2;
    localparam logic [2:0] S_ROW2 = 3'd3;
`endif
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [PP_BUS_W-1:0] pp_q, pp_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [PROD_W-1:0]   w_add;

`ifdef MULTI_PP_FAST_EN
    // All 15 terms summed at once; each term is zero-extended before its
    // row/column shift so nothing is lost off the top of the 43-bit slice.
    always_comb begin
        w_add = '0;
        for (int k = 0; k < N_A * N_B; k++) begin
            w_add = w_add + (PROD_W'(pp_q[k*PP_W +: PP_W])
                             << (A_LIMB * (k / N_B) + B_LIMB * (k % N_B)));
        end
    end
`else
    logic [1:0]          w_row_idx;
    logic [N_B*PP_W-1:0] w_row_pp;
    logic [PROD_W-1:0]   w_row_sum;

    // One shared row adder: pick the active row's 5 products, sum them with
    // their column shifts, then apply the row shift once on the result.
    always_comb begin
        case (state_q)
            S_ROW1:  w_row_idx = 2'd1;
            S_ROW2:  w_row_idx = 2'd2;
            default: w_row_idx = 2'd0;
        endcase
        w_row_pp  = pp_q[w_row_idx*N_B*PP_W +: N_B*PP_W];
        w_row_sum = '0;
        for (int j = 0; j < N_B; j++) begin
            w_row_sum = w_row_sum + (PROD_W'(w_row_pp[j*PP_W +: PP_W]) << (B_LIMB * j));
        end
        w_add = w_row_sum << (A_LIMB * w_row_idx);
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pp_q  <= '0;
            acc_q <= '0;
        end else begin
            pp_q  <= pp_d;
            acc_q <= acc_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pp_d    = pp_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pp_d  = pp;
                    acc_d = '0;
`ifdef MULTI_PP_FAST_EN
                    state_d = S_SUM;
`else
                    state_d = S_ROW0;
`endif
                end
            end
`ifdef MULTI_PP_FAST_EN
            S_SUM: begin
                acc_d   = acc_q + w_add;
                state_d = S_DONE;
            end
`else
            S_ROW0: begin
                acc_d   = acc_q + w_add;
                state_d = S_ROW1;
            end
            S_ROW1: begin
                acc_d   = acc_q + w_add;
                state_d = S_ROW2;
            end
            S_ROW2: begin
                acc_d   = acc_q + w_add;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                // Back to IDLE only; a new accept always needs an IDLE cycle.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        prod      = acc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_pp_accum.sv
`default_nettype none
module tb_multi_pp_accum;

    localparam int PP_W   = 43;
    localparam int BUS_W  = 15 * PP_W;
    localparam int PROD_W = 156;
    localparam int N_RAND = 1000;
`ifdef MULTI_PP_FAST_EN
    localparam int LAT      = 2;
    localparam int PERIOD   = 3;
    localparam int RST_WAIT = 1;
`else
    localparam int LAT      = 4;
    localparam int PERIOD   = 5;
    localparam int RST_WAIT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [BUS_W-1:0]  pp;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] prod;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_pp_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp        (pp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
    );

    typedef struct {
        logic [BUS_W-1:0]  pp;
        logic [PROD_W-1:0] exp;
        string             name;
    } vec_t;

    vec_t              vecs[7];
    logic [PROD_W-1:0] ref_q[$];

    // Upstream limb multiplier: pp_{i*5+j} = a_limb_i * b_limb_j
    function automatic logic [BUS_W-1:0] make_pp(input logic [77:0] a, input logic [77:0] b);
        logic [84:0]      bx;
        logic [BUS_W-1:0] r;
        logic [42:0]      p;
        bx = {7'b0, b};
        r  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 5; j++) begin
                p = 43'(a[26*i +: 26]) * 43'(bx[17*j +: 17]);
                r[(i*5+j)*PP_W +: PP_W] = p;
            end
        end
        return r;
    endfunction

    function automatic logic [PROD_W-1:0] golden(input logic [77:0] a, input logic [77:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

    function automatic logic [77:0] rnd78();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[77:0];
    endfunction

    task automatic check(input string name, input logic [PROD_W-1:0] got, input logic [PROD_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Full transaction with out_ready held high: accept, latency, value, drop.
    task automatic send_set(input string name, input logic [BUS_W-1:0] v, input logic [PROD_W-1:0] want);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready"}, PROD_W'(in_ready), PROD_W'(1));
        pp       = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pp       = '0;
        n        = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, PROD_W'(n), PROD_W'(LAT));
        check({name, " prod"}, prod, want);
        @(negedge clk);
        check({name, " drop"}, PROD_W'(out_valid), PROD_W'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [77:0]       a;
        logic [77:0]       b;
        logic [PROD_W-1:0] want;
        int                n;
        int                cyc;
        int                last;
        int                sent;
        int                got;
        bit                acc_prev;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pp        = '0;

        vecs[0].pp = '0; vecs[0].pp[0]       = 1'b1; vecs[0].exp = 156'd1;         vecs[0].name = "pp0";
        vecs[1].pp = '0; vecs[1].pp[14*PP_W] = 1'b1; vecs[1].exp = 156'd1 << 120;  vecs[1].name = "pp14";
        vecs[2].pp = '0; vecs[2].pp[6*PP_W]  = 1'b1; vecs[2].exp = 156'd1 << 43;   vecs[2].name = "pp6";
        vecs[3].pp = make_pp({78{1'b1}}, {78{1'b1}});
        vecs[3].exp = 156'd0 - (156'd1 << 79) + 156'd1;                            vecs[3].name = "maxmax";
        vecs[4].pp = '0; vecs[4].pp[4*PP_W]  = 1'b1; vecs[4].exp = 156'd1 << 68;   vecs[4].name = "pp4";
        vecs[5].pp = '0; vecs[5].pp[10*PP_W] = 1'b1; vecs[5].exp = 156'd1 << 52;   vecs[5].name = "pp10";
        vecs[6].pp = make_pp(78'd1 << 77, 78'd1 << 77);
        vecs[6].exp = 156'd1 << 154;                                               vecs[6].name = "toptop";

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", PROD_W'(in_ready), PROD_W'(1));
        check("rst out_valid", PROD_W'(out_valid), PROD_W'(0));
        check("rst prod", prod, '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            send_set(vecs[i].name, vecs[i].pp, vecs[i].exp);
        end

        // Back-pressure: hold DONE for 10 cycles, in_valid must be ignored
        a = rnd78();
        b = rnd78();
        want      = golden(a, b);
        out_ready = 1'b0;
        pp        = make_pp(a, b);
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            check("bp prod", prod, want);
            check("bp out_valid", PROD_W'(out_valid), PROD_W'(1));
            check("bp in_ready", PROD_W'(in_ready), PROD_W'(0));
            in_valid = 1'b1;
            pp       = make_pp(rnd78(), rnd78());
            @(negedge clk);
        end
        check("bp hold prod", prod, want);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", PROD_W'(out_valid), PROD_W'(0));
        check("bp release in_ready", PROD_W'(in_ready), PROD_W'(1));
        @(negedge clk);
        check("bp idle in_ready", PROD_W'(in_ready), PROD_W'(1));
        a = rnd78();
        b = rnd78();
        send_set("after bp", make_pp(a, b), golden(a, b));

        // Reset in the middle of accumulation
        a = rnd78();
        b = rnd78();
        pp       = make_pp(a, b);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (RST_WAIT - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst out_valid", PROD_W'(out_valid), PROD_W'(0));
        check("midrst in_ready", PROD_W'(in_ready), PROD_W'(1));
        check("midrst prod", prod, '0);
        repeat (LAT + 1) @(negedge clk);
        check("midrst dropped", PROD_W'(out_valid), PROD_W'(0));
        a = rnd78();
        b = rnd78();
        send_set("after rst", make_pp(a, b), golden(a, b));

        // Random back-to-back sets against a*b
        ref_q.delete();
        a        = rnd78();
        b        = rnd78();
        pp       = make_pp(a, b);
        in_valid = 1'b1;
        sent     = 0;
        got      = 0;
        last     = -1;
        cyc      = 0;
        acc_prev = 1'b0;
        while ((sent < N_RAND || got < N_RAND) && cyc < N_RAND * PERIOD + 200) begin
            if (acc_prev) begin
                if (sent < N_RAND) begin
                    a  = rnd78();
                    b  = rnd78();
                    pp = make_pp(a, b);
                end else begin
                    in_valid = 1'b0;
                end
                acc_prev = 1'b0;
            end
            if (out_valid) begin
                if (ref_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rand unexpected out_valid got=%h want=none", prod);
                end else begin
                    check("rand prod", prod, ref_q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ref_q.push_back(golden(a, b));
                if (last >= 0) begin
                    check("rand spacing", PROD_W'(cyc - last), PROD_W'(PERIOD));
                end
                last     = cyc;
                sent++;
                acc_prev = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("rand sent", PROD_W'(sent), PROD_W'(N_RAND));
        check("rand got", PROD_W'(got), PROD_W'(N_RAND));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
